integration_scheduler: RTL and testbench
========================================

// Module: integration_scheduler
// PURPOSE
//  Sequences the correlator integration windows. Generates a counter clear, a snapshot
//  strobe for the TX frame buffer and a req/ack start towards the UART word transmitter.
//  Sits between the config registers (UART command decoder) and the pulse_counter array
//  plus tx_data latch. Replaces the edge-triggered reset_correlator/tx_data loading with
//  one synchronous clk-domain schedule.
// PARAMETERS
//  TIME_W    64  width of integration period, in clk cycles
//  FRAME_W   16  width of frame_id
//  MIN_TIME  4   minimum integration period; smaller requests are clamped to this
// PORTS
//  clk                input   1        system clock, all logic on posedge
//  reset              input   1        synchronous, active-high
//  enable             input   1        run integration windows (sample_clock_enable)
//  integration_cycles input   TIME_W   requested period P
//  cfg_load           input   1        1-cycle pulse: latch integration_cycles, applied at next boundary
//  tx_busy            input   1        transmitter busy; acts as ack for tx_start
//  counter_clear      output  1        1-cycle pulse: pulse counters clear (sync, priority over count)
//  snapshot           output  1        1-cycle pulse: TX buffer latches counter values this cycle
//  tx_start           output  1        level request to transmitter
//  frame_id           output  FRAME_W  index of the last closed window, wraps
//  overrun_count      output  8        windows dropped because TX was not free, saturating at 255
//  active             output  1        high in START/RUN
// BEHAVIOUR
//  Reset: all outputs 0; main FSM=IDLE; TX FSM=TX_IDLE; period_reg=MIN_TIME; cfg_pending=0.
//  Main FSM: IDLE -> START (enable sampled 1) -> RUN.
//  - START (1 cycle): counter_clear=1; period_reg<=max(pending or current cfg, MIN_TIME); timer<=period_reg-1.
//  - RUN: timer decrements each cycle. Terminal cycle is timer==0, exactly P cycles after START.
//  - Terminal cycle: counter_clear=1; timer reloads; frame_id+1 (mod 2^FRAME_W).
//    - If TX FSM==TX_IDLE and tx_busy==0: snapshot=1.
//    - Otherwise snapshot=0 and overrun_count+1, saturating. Clear is still issued.
//    - If cfg_pending: period_reg takes the new value, cfg_pending<=0; the reload uses the new period.
//  - enable==0 sampled in START/RUN: next state IDLE. No snapshot; the current partial window is discarded.
//  - Simultaneous enable fall and terminal cycle: the terminal actions happen, then IDLE.
//  cfg_load: captures integration_cycles into cfg_shadow and sets cfg_pending. A later cfg_load
//  before the boundary overwrites it (last wins). In IDLE the value takes effect at START.
//  TX FSM: TX_IDLE -> TX_REQ the cycle after snapshot. tx_start=1 while in TX_REQ.
//  - TX_REQ -> TX_WAIT when tx_busy==1 is sampled (tx_start drops the next cycle).
//  - TX_WAIT -> TX_IDLE when tx_busy==0.
//  - TX FSM runs independently of enable. A request already issued completes after enable falls.
//  Latency: enable high at edge k -> counter_clear at cycle k+1 -> first snapshot at cycle k+1+P
//  -> tx_start at k+2+P.
//  Arithmetic: timer is TIME_W wide; clamp compares full width; frame_id wraps 2^FRAME_W-1 -> 0.
//  Reset mid-operation: immediate return to reset values. An in-flight TX request is abandoned.
// CONFIGURATION
//  SCHED_TIMESTAMP_EN defined:
//  - adds output timestamp[47:0] and a free-running 48-bit clk-cycle counter (reset 0, wraps).
//  - timestamp latches the counter value in every cycle where snapshot=1.
//  - the TX frame header carries it.
//  Undefined: no timestamp port and no counter logic.
// TESTING
//  P=10, enable at edge 0, tx_busy=0 -> counter_clear at cycles 1,11,21; snapshot at 11,21; frame_id 1,2.
//  integration_cycles=2, cfg_load in IDLE, enable -> period clamped: terminal every 4 cycles.
//  tx_busy ack 3 cycles after tx_start and held 30 cycles with P=10 -> next window: snapshot=0,
//    overrun_count=1, counter_clear=1, frame_id still increments.
//  cfg_load 20 during a P=10 window at timer=5 -> that window ends at P=10; the next lasts 20.
//  enable falls at timer=3 -> no snapshot, active=0 next cycle. Pending tx_start still completes on ack.
//  reset asserted in RUN with tx_start=1 -> next cycle all outputs 0, FSMs idle, overrun_count=0.

Source files
------------

// File: rtl/integration_scheduler.sv
// Integration window scheduler: counter clear, TX snapshot and req/ack start to the UART
// transmitter. Optional SCHED_TIMESTAMP_EN adds a 48-bit snapshot timestamp.
module integration_scheduler #(
    parameter int unsigned TIME_W   = 64,
    parameter int unsigned FRAME_W  = 16,
    parameter int unsigned MIN_TIME = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [TIME_W-1:0]  integration_cycles,
    input  logic               cfg_load,
    input  logic               tx_busy,
    output logic               counter_clear,
    output logic               snapshot,
    output logic               tx_start,
    output logic [FRAME_W-1:0] frame_id,
    output logic [7:0]         overrun_count,
`ifdef SCHED_TIMESTAMP_EN
    output logic [47:0]        timestamp,
`endif
    output logic               active
);

    localparam logic [TIME_W-1:0] MinTime = TIME_W'(MIN_TIME);

    typedef enum logic [1:0] {StIdle, StStart, StRun} main_state_e;
    typedef enum logic [1:0] {TxIdle, TxReq, TxWait} tx_state_e;

    main_state_e        state_q, state_d;
    tx_state_e          tx_state_q, tx_state_d;
    logic [TIME_W-1:0]  timer_q, timer_d;
    logic [TIME_W-1:0]  period_q, period_d;
    logic [TIME_W-1:0]  cfg_shadow_q, cfg_shadow_d;
    logic               cfg_pending_q, cfg_pending_d;
    logic [FRAME_W-1:0] frame_id_q, frame_id_d;
    logic [7:0]         overrun_q, overrun_d;

    logic [TIME_W-1:0]  period_sel;
    logic [TIME_W-1:0]  period_new;
    logic               tx_free;

    always_comb begin
        period_sel = cfg_pending_q ? cfg_shadow_q : period_q;
        period_new = (period_sel < MinTime) ? MinTime : period_sel;
        tx_free    = (tx_state_q == TxIdle) && !tx_busy;

        state_d       = state_q;
        timer_d       = timer_q;
        period_d      = period_q;
        cfg_shadow_d  = cfg_shadow_q;
        cfg_pending_d = cfg_pending_q;
        frame_id_d    = frame_id_q;
        overrun_d     = overrun_q;
        counter_clear = 1'b0;
        snapshot      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StStart;
            end
            StStart: begin
                counter_clear = 1'b1;
                period_d      = period_new;
                timer_d       = period_new - TIME_W'(1);
                cfg_pending_d = 1'b0;
                state_d       = enable ? StRun : StIdle;
            end
            StRun: begin
                if (timer_q == '0) begin
                    counter_clear = 1'b1;
                    period_d      = period_new;
                    timer_d       = period_new - TIME_W'(1);
                    cfg_pending_d = 1'b0;
                    frame_id_d    = frame_id_q + FRAME_W'(1);
                    if (tx_free) begin
                        snapshot = 1'b1;
                    end else if (overrun_q != 8'hff) begin
                        overrun_d = overrun_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q - TIME_W'(1);
                end
                // Terminal actions above still apply when enable drops on the same cycle.
                if (!enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A load on the consuming boundary re-arms, so the newest value is never lost.
        if (cfg_load) begin
            cfg_shadow_d  = integration_cycles;
            cfg_pending_d = 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TxIdle:  if (snapshot) tx_state_d = TxReq;
            TxReq:   if (tx_busy)  tx_state_d = TxWait;
            TxWait:  if (!tx_busy) tx_state_d = TxIdle;
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tx_state_q    <= TxIdle;
            timer_q       <= '0;
            period_q      <= MinTime;
            cfg_shadow_q  <= '0;
            cfg_pending_q <= 1'b0;
            frame_id_q    <= '0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            tx_state_q    <= tx_state_d;
            timer_q       <= timer_d;
            period_q      <= period_d;
            cfg_shadow_q  <= cfg_shadow_d;
            cfg_pending_q <= cfg_pending_d;
            frame_id_q    <= frame_id_d;
            overrun_q     <= overrun_d;
        end
    end

    assign tx_start      = (tx_state_q == TxReq);
    assign active        = (state_q != StIdle);
    assign frame_id      = frame_id_q;
    assign overrun_count = overrun_q;

`ifdef SCHED_TIMESTAMP_EN
    logic [47:0] ts_cnt_q, ts_cnt_d;
    logic [47:0] timestamp_q, timestamp_d;

    always_comb begin
        ts_cnt_d    = ts_cnt_q + 48'd1;
        timestamp_d = snapshot ? ts_cnt_q : timestamp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q    <= '0;
            timestamp_q <= '0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            timestamp_q <= timestamp_d;
        end
    end

    assign timestamp = timestamp_q;
`endif

endmodule

// File: tb/tb_integration_scheduler.sv
// Directed self-checking bench for integration_scheduler with a simple transmitter responder.
module tb_integration_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [63:0] integration_cycles;
    logic        cfg_load;
    logic        tx_busy;
    logic        counter_clear;
    logic        snapshot;
    logic        tx_start;
    logic [15:0] frame_id;
    logic [7:0]  overrun_count;
    logic        active;

    int n_checks = 0;
    int n_pass   = 0;

    // Responder controls: ack tx_start after ack_delay cycles, hold busy for hold cycles.
    logic resp_en   = 1'b0;
    int   ack_delay = 1;
    int   hold      = 1;

    integration_scheduler #(
        .TIME_W  (64),
        .FRAME_W (16),
        .MIN_TIME(4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .integration_cycles(integration_cycles),
        .cfg_load          (cfg_load),
        .tx_busy           (tx_busy),
        .counter_clear     (counter_clear),
        .snapshot          (snapshot),
        .tx_start          (tx_start),
        .frame_id          (frame_id),
        .overrun_count     (overrun_count),
        .active            (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int rd_cnt;
        int hold_cnt;
        rd_cnt   = 0;
        hold_cnt = 0;
        tx_busy  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                tx_busy  = 1'b0;
                rd_cnt   = 0;
                hold_cnt = 0;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_busy = 1'b0;
            end else if (tx_start) begin
                rd_cnt++;
                if (rd_cnt >= ack_delay) begin
                    tx_busy  = 1'b1;
                    hold_cnt = hold;
                    rd_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        cfg_load = 1'b0;
        resp_en  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Loads period p in IDLE, raises enable; returns positioned in cycle 1 (START).
    task automatic start_run(input logic [63:0] p);
        cfg_load           = 1'b1;
        integration_cycles = p;
        step();
        cfg_load = 1'b0;
        enable   = 1'b1;
        step();
    endtask

    task automatic test_reset();
        integration_cycles = 64'd0;
        do_reset();
        n_checks++;
        if ({counter_clear, snapshot, tx_start, active} !== 4'b0000 || frame_id !== 16'd0 ||
            overrun_count !== 8'd0)
            $display("FAIL reset_outputs: clr=%b snap=%b start=%b act=%b fid=%0d ovr=%0d want all 0",
                     counter_clear, snapshot, tx_start, active, frame_id, overrun_count);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic exp_clr, exp_snap;
        do_reset();
        resp_en   = 1'b1;
        ack_delay = 1;
        hold      = 2;
        start_run(64'd10);
        for (int c = 1; c <= 25; c++) begin
            exp_clr  = (c == 1 || c == 11 || c == 21);
            exp_snap = (c == 11 || c == 21);
            n_checks++;
            if (counter_clear !== exp_clr || snapshot !== exp_snap || active !== 1'b1)
                $display("FAIL basic_c%0d: clr=%b snap=%b act=%b want clr=%b snap=%b act=1",
                         c, counter_clear, snapshot, active, exp_clr, exp_snap);
            else n_pass++;
            if (c == 12 || c == 22) begin
                n_checks++;
                if (frame_id !== ((c == 12) ? 16'd1 : 16'd2) || tx_start !== 1'b1)
                    $display("FAIL basic_frame_c%0d: fid=%0d start=%b want fid=%0d start=1",
                             c, frame_id, tx_start, (c == 12) ? 1 : 2);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if (overrun_count !== 8'd0)
            $display("FAIL basic_overrun: got %0d want 0", overrun_count);
        else n_pass++;
    endtask

    task automatic test_clamp();
        logic exp_clr;
        do_reset();
        resp_en   = 1'b1;
        ack_delay = 1;
        hold      = 1;
        start_run(64'd2);
        for (int c = 1; c <= 13; c++) begin
            exp_clr = ((c - 1) % 4 == 0);
            n_checks++;
            if (counter_clear !== exp_clr)
                $display("FAIL clamp_c%0d: clr=%b want %b", c, counter_clear, exp_clr);
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if (snapshot !== 1'b1) $display("FAIL clamp_snap: got %b want 1", snapshot);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_overrun();
        do_reset();
        resp_en   = 1'b1;
        ack_delay = 3;
        hold      = 30;
        start_run(64'd10);
        for (int c = 1; c <= 32; c++) begin
            if (c == 21) begin
                n_checks++;
                if (counter_clear !== 1'b1 || snapshot !== 1'b0)
                    $display("FAIL overrun_term: clr=%b snap=%b want clr=1 snap=0",
                             counter_clear, snapshot);
                else n_pass++;
            end
            if (c == 22) begin
                n_checks++;
                if (overrun_count !== 8'd1 || frame_id !== 16'd2)
                    $display("FAIL overrun_cnt: ovr=%0d fid=%0d want ovr=1 fid=2",
                             overrun_count, frame_id);
                else n_pass++;
            end
            if (c == 32) begin
                n_checks++;
                if (overrun_count !== 8'd2 || frame_id !== 16'd3)
                    $display("FAIL overrun_cnt2: ovr=%0d fid=%0d want ovr=2 fid=3",
                             overrun_count, frame_id);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_cfg_midwindow();
        do_reset();
        resp_en   = 1'b1;
        ack_delay = 1;
        hold      = 1;
        start_run(64'd10);
        for (int c = 1; c <= 31; c++) begin
            cfg_load = 1'b0;
            if (c == 6) begin
                cfg_load           = 1'b1;
                integration_cycles = 64'd20;
            end
            if (c == 11 || c == 21 || c == 31) begin
                n_checks++;
                if (counter_clear !== (c != 21) || snapshot !== (c != 21))
                    $display("FAIL cfg_c%0d: clr=%b snap=%b want %b", c, counter_clear, snapshot,
                             (c != 21));
                else n_pass++;
            end
            step();
        end
        cfg_load = 1'b0;
    endtask

    task automatic test_enable_fall();
        logic saw_snap;
        logic dropped;
        do_reset();
        start_run(64'd10);
        for (int c = 1; c < 18; c++) step();
        enable = 1'b0;
        step();
        n_checks++;
        if (active !== 1'b0 || tx_start !== 1'b1)
            $display("FAIL fall_active: act=%b start=%b want act=0 start=1", active, tx_start);
        else n_pass++;
        saw_snap = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (snapshot || counter_clear) saw_snap = 1'b1;
            step();
        end
        n_checks++;
        if (saw_snap !== 1'b0 || frame_id !== 16'd1)
            $display("FAIL fall_nosnap: snap_seen=%b fid=%0d want 0 fid=1", saw_snap, frame_id);
        else n_pass++;
        resp_en   = 1'b1;
        ack_delay = 1;
        hold      = 2;
        dropped   = 1'b0;
        for (int c = 0; c < 10 && !dropped; c++) begin
            step();
            if (!tx_start) dropped = 1'b1;
        end
        n_checks++;
        if (dropped !== 1'b1) $display("FAIL fall_tx_complete: tx_start=%b want 0", tx_start);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start_run(64'd10);
        for (int c = 1; c < 23; c++) step();
        n_checks++;
        if (overrun_count !== 8'd1 || tx_start !== 1'b1 || active !== 1'b1)
            $display("FAIL midrun_pre: ovr=%0d start=%b act=%b want ovr=1 start=1 act=1",
                     overrun_count, tx_start, active);
        else n_pass++;
        reset  = 1'b1;
        enable = 1'b0;
        step();
        reset = 1'b0;
        n_checks++;
        if ({counter_clear, snapshot, tx_start, active} !== 4'b0000 || frame_id !== 16'd0 ||
            overrun_count !== 8'd0)
            $display("FAIL midrun_reset: clr=%b snap=%b start=%b act=%b fid=%0d ovr=%0d want 0",
                     counter_clear, snapshot, tx_start, active, frame_id, overrun_count);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        start_run(64'd4);
        for (int c = 1; c < 1042; c++) step();
        n_checks++;
        if (overrun_count !== 8'd255 || frame_id !== 16'd260)
            $display("FAIL saturate: ovr=%0d fid=%0d want ovr=255 fid=260",
                     overrun_count, frame_id);
        else n_pass++;
    endtask

    initial begin
        reset              = 1'b1;
        enable             = 1'b0;
        cfg_load           = 1'b0;
        integration_cycles = 64'd0;
        test_reset();
        test_basic();
        test_clamp();
        test_overrun();
        test_cfg_midwindow();
        test_enable_fall();
        test_reset_midrun();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
